// File: rtl/hier_probe_pkg.sv
// -----------------------------------------------------------------------------
// hier_probe_pkg
// Shared constants and types for the hier_probe_dut hierarchy.
//   RST_ACTIVE  : level of the reset input that holds the flops cleared
//   stage_t     : one-bit stage value carried through the chain
//   INIT_A_DEF  : default for the initA elaboration switch
//   INIT_C_DEF  : default for the initC elaboration switch
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package hier_probe_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    typedef logic stage_t;

    localparam int INIT_A_DEF = 1;
    localparam int INIT_C_DEF = 1;

endpackage : hier_probe_pkg

// File: rtl/hier_probe_ab_stage.sv
// -----------------------------------------------------------------------------
// ab_stage
// Two registered stages: int_AB samples a_i, and int_CD (present only when
// initC==1, inside generate block C_blk) samples int_AB ^ e_i.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active at RST_ACTIVE (low)
//   a_i    in   stage-1 data
//   e_i    in   stage-2 modifier
//   b_o    out  int_AB
//   d_o    out  int_CD when C_blk exists, else 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ab_stage
    import hier_probe_pkg::*;
#(
    parameter int initC = INIT_C_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  stage_t a_i,
    input  stage_t e_i,
    output stage_t b_o,
    output stage_t d_o
);

    // The names int_AB / int_CD and the label C_blk are probed by benches
    // through fixed hierarchical paths; do not rename them.
    stage_t int_AB;

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RST_ACTIVE) begin
            int_AB <= 1'b0;
        end else begin
            int_AB <= a_i;
        end
    end

    assign b_o = int_AB;

    generate
        if (initC == 1) begin : C_blk
            stage_t int_CD;

            always_ff @(posedge clk or negedge reset) begin
                if (reset == RST_ACTIVE) begin
                    int_CD <= 1'b0;
                end else begin
                    int_CD <= int_AB ^ e_i;
                end
            end

            assign d_o = int_CD;
        end else begin : no_C_blk
            // Stage 2 is elaborated away; the modifier input has no load.
            logic unused_e;
            assign unused_e = e_i;
            assign d_o      = 1'b0;
        end
    endgenerate

endmodule : ab_stage

// File: rtl/hier_probe_dut.sv
// -----------------------------------------------------------------------------
// hier_probe_dut
// Top wrapper: optionally elaborates generate block A_blk holding the ab_stage
// instance A_mod, and ties the outputs low when that block is absent.
// Parameters (positional order initA, initC):
//   initA  1: build A_blk/A_mod; 0: no flops, outputs tied to 0
//   initC  1: build C_blk inside A_mod; 0: D tied to 0
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active low
//   A      in   stage-1 data input
//   E      in   stage-2 modifier input
//   B      out  stage-1 result (int_AB)
//   D      out  stage-2 result (int_CD)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hier_probe_dut
    import hier_probe_pkg::*;
#(
    parameter int initA = INIT_A_DEF,
    parameter int initC = INIT_C_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  stage_t A,
    input  stage_t E,
    output stage_t B,
    output stage_t D
);

    generate
        if (initA == 1) begin : A_blk
            stage_t b_w;
            stage_t d_w;

            ab_stage #(
                .initC (initC)
            ) A_mod (
                .clk   (clk),
                .reset (reset),
                .a_i   (A),
                .e_i   (E),
                .b_o   (b_w),
                .d_o   (d_w)
            );

            assign B = b_w;
            assign D = d_w;
        end else begin : no_A_blk
            // Whole chain elaborated away; inputs are intentionally unloaded.
            logic unused_in;
            assign unused_in = ^{clk, reset, A, E};
            assign B         = 1'b0;
            assign D         = 1'b0;
        end
    endgenerate

endmodule : hier_probe_dut

// File: tb/tb_hier_probe_dut.sv
`timescale 1ns/1ps
module tb_hier_probe_dut;

    logic clk = 1'b0;
    logic reset;
    logic A;
    logic E;
    logic B, D;
    logic B_c0, D_c0;
    logic B_a0, D_a0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Full chain (default parameters)
    hier_probe_dut dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .E     (E),
        .B     (B),
        .D     (D)
    );

    // Stage 2 removed
    hier_probe_dut #(1, 0) dut_c0 (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .E     (E),
        .B     (B_c0),
        .D     (D_c0)
    );

    // Whole chain removed
    hier_probe_dut #(0, 0) dut_a0 (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .E     (E),
        .B     (B_a0),
        .D     (D_a0)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Compare every instance and the probed internals against one expected pair.
    task automatic check_all(input string tag, input logic exp_b, input logic exp_d);
        check({tag, ".B"},        B,                               exp_b);
        check({tag, ".D"},        D,                               exp_d);
        check({tag, ".int_AB"},   dut.A_blk.A_mod.int_AB,          exp_b);
        check({tag, ".int_CD"},   dut.A_blk.A_mod.C_blk.int_CD,    exp_d);
        check({tag, ".c0.B"},     B_c0,                            exp_b);
        check({tag, ".c0.int_AB"},dut_c0.A_blk.A_mod.int_AB,       exp_b);
        check({tag, ".c0.D"},     D_c0,                            1'b0);
        check({tag, ".a0.B"},     B_a0,                            1'b0);
        check({tag, ".a0.D"},     D_a0,                            1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with active inputs: nothing loads
        reset = 1'b0;
        A     = 1'b1;
        E     = 1'b1;
        #1;
        check_all("rst_t0", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("rst_e%0d", i), 1'b0, 1'b0);
        end

        // Release, A=1 E=0: B after one edge, D after two
        @(negedge clk);
        reset = 1'b1;
        A     = 1'b1;
        E     = 1'b0;
        tick();
        check_all("rel_e1", 1'b1, 1'b0);
        tick();
        check_all("rel_e2", 1'b1, 1'b1);

        // E=1 with A=1: D = 1^1 = 0; then E=0 -> D=1 one edge later
        @(negedge clk);
        E = 1'b1;
        tick();
        check_all("e1_xor", 1'b1, 1'b0);
        @(negedge clk);
        E = 1'b0;
        tick();
        check_all("e0_xor", 1'b1, 1'b1);

        // Mid-cycle reset clears immediately and holds across an edge
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_clr", 1'b0, 1'b0);
        tick();
        check_all("held_clr", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        A     = 1'b1;
        E     = 1'b0;
        #1;
        check_all("rel_noedge", 1'b0, 1'b0);
        tick();
        check_all("rel2_e1", 1'b1, 1'b0);
        tick();
        check_all("rel2_e2", 1'b1, 1'b1);

        // Further patterns: D = previous B ^ current E
        @(negedge clk);
        A = 1'b0;
        E = 1'b1;
        tick();
        check_all("pat_a0e1", 1'b0, 1'b0);
        @(negedge clk);
        A = 1'b1;
        E = 1'b1;
        tick();
        check_all("pat_a1e1", 1'b1, 1'b1);
        @(negedge clk);
        A = 1'b0;
        E = 1'b0;
        tick();
        check_all("pat_a0e0", 1'b0, 1'b1);
        tick();
        check_all("pat_flush", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hier_probe_dut
